// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg
// Shared types and constants for the register-file writeback arbiter.
//   wb_req_t  : default-width {rd, data} writeback record
//   wb_src_e  : writeback source select (ALU result path / load-data path)
//   REG_ZERO  : index of the hard-wired zero register, never written
package regfile_wb_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_slot.sv
// wb_slot
// One-entry writeback holding buffer with a valid/ready handshake.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : request handshake from the producing stage
//   in_rd, in_data        : destination register and write data
//   grant                 : arbiter is draining this entry this cycle
//   full, slot_rd/data    : current buffer contents
//   fill, drain           : strobes for an entry being written / granted
//   full_next             : buffer occupancy after the coming edge
module wb_slot #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_DATA_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_DATA_WIDTH-1:0] in_rd,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      grant,
    output logic                      full,
    output logic [REG_DATA_WIDTH-1:0] slot_rd,
    output logic [DATA_WIDTH-1:0]     slot_data,
    output logic                      fill,
    output logic                      drain,
    output logic                      full_next
);
    import regfile_wb_pkg::*;

    logic                      full_q, full_d;
    logic [REG_DATA_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;

    // A full buffer being granted can take a new entry in the same cycle.
    // Writes to x0 complete the handshake but are dropped here so they
    // never reach the arbiter or the pending mask.
    always_comb begin
        in_ready = !full_q || grant;
        fill     = in_valid && in_ready && (in_rd != REG_DATA_WIDTH'(REG_ZERO));
        drain    = full_q && grant;
        full_d   = full_q;
        rd_d     = rd_q;
        data_d   = data_q;
        if (drain) begin
            full_d = 1'b0;
        end
        if (fill) begin
            full_d = 1'b1;
            rd_d   = in_rd;
            data_d = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            rd_q   <= rd_d;
            data_q <= data_d;
        end
    end

    assign full      = full_q;
    assign slot_rd   = rd_q;
    assign slot_data = data_q;
    assign full_next = full_d;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register file's single write port between the ALU result path
// and the load-data path. Each source has a one-entry buffer; the arbiter
// picks round-robin between different destinations and oldest-first for the
// same destination, and drives the write port from registers.
// Ports:
//   clk, rst_n                       : clock, synchronous active-low reset
//   alu_valid/ready, alu_rd/data     : ALU writeback request
//   ld_valid/ready, ld_rd/data       : load writeback request
//   RegWrite, rd, ALUout             : register file WE3 / A3 / WD3
//   pending                          : registers with accepted, uncommitted writes
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_DATA_WIDTH = 5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           alu_valid,
    output logic                           alu_ready,
    input  logic [REG_DATA_WIDTH-1:0]      alu_rd,
    input  logic [DATA_WIDTH-1:0]          alu_data,
    input  logic                           ld_valid,
    output logic                           ld_ready,
    input  logic [REG_DATA_WIDTH-1:0]      ld_rd,
    input  logic [DATA_WIDTH-1:0]          ld_data,
    output logic                           RegWrite,
    output logic [REG_DATA_WIDTH-1:0]      rd,
    output logic [DATA_WIDTH-1:0]          ALUout,
    output logic [2**REG_DATA_WIDTH-1:0]   pending
);
    import regfile_wb_pkg::*;

    localparam int NUM_REGS = 2**REG_DATA_WIDTH;

    logic                      alu_full, alu_fill, alu_drain, alu_full_next;
    logic [REG_DATA_WIDTH-1:0] alu_slot_rd;
    logic [DATA_WIDTH-1:0]     alu_slot_data;
    logic                      ld_full, ld_fill, ld_drain, ld_full_next;
    logic [REG_DATA_WIDTH-1:0] ld_slot_rd;
    logic [DATA_WIDTH-1:0]     ld_slot_data;

    logic    any_grant, contended, alu_grant, ld_grant;
    wb_src_e grant_src;

    // rr_alu_q = 1: ALU wins the next contended grant.
    // ld_older_q = 1: the load entry was accepted first.
    logic                      rr_alu_q, rr_alu_d;
    logic                      ld_older_q, ld_older_d;
    logic                      reg_write_q, reg_write_d;
    logic [REG_DATA_WIDTH-1:0] wr_rd_q, wr_rd_d;
    logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
    logic [NUM_REGS-1:0]       pending_c;

    wb_slot #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_DATA_WIDTH (REG_DATA_WIDTH)
    ) u_alu_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (alu_valid),
        .in_ready  (alu_ready),
        .in_rd     (alu_rd),
        .in_data   (alu_data),
        .grant     (alu_grant),
        .full      (alu_full),
        .slot_rd   (alu_slot_rd),
        .slot_data (alu_slot_data),
        .fill      (alu_fill),
        .drain     (alu_drain),
        .full_next (alu_full_next)
    );

    wb_slot #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_DATA_WIDTH (REG_DATA_WIDTH)
    ) u_ld_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (ld_valid),
        .in_ready  (ld_ready),
        .in_rd     (ld_rd),
        .in_data   (ld_data),
        .grant     (ld_grant),
        .full      (ld_full),
        .slot_rd   (ld_slot_rd),
        .slot_data (ld_slot_data),
        .fill      (ld_fill),
        .drain     (ld_drain),
        .full_next (ld_full_next)
    );

    // Same destination must commit in acceptance order, so age beats the
    // round-robin pointer there; only different destinations consume rr.
    always_comb begin
        any_grant = 1'b0;
        contended = 1'b0;
        grant_src = SRC_ALU;
        if (alu_full && ld_full) begin
            any_grant = 1'b1;
            if (alu_slot_rd == ld_slot_rd) begin
                grant_src = ld_older_q ? SRC_LD : SRC_ALU;
            end else begin
                contended = 1'b1;
                grant_src = rr_alu_q ? SRC_ALU : SRC_LD;
            end
        end else if (alu_full) begin
            any_grant = 1'b1;
            grant_src = SRC_ALU;
        end else if (ld_full) begin
            any_grant = 1'b1;
            grant_src = SRC_LD;
        end
        alu_grant = any_grant && (grant_src == SRC_ALU);
        ld_grant  = any_grant && (grant_src == SRC_LD);
        rr_alu_d  = contended ? !rr_alu_q : rr_alu_q;
    end

    // The age flag only matters while both buffers are full; otherwise it
    // simply tracks whichever entry will be left on its own.
    always_comb begin
        ld_older_d = ld_older_q;
        if (alu_fill && ld_fill) begin
            ld_older_d = 1'b1;
        end else if (alu_fill && ld_full && !ld_drain) begin
            ld_older_d = 1'b1;
        end else if (ld_fill && alu_full && !alu_drain) begin
            ld_older_d = 1'b0;
        end else if (alu_full_next && !ld_full_next) begin
            ld_older_d = 1'b0;
        end else if (ld_full_next && !alu_full_next) begin
            ld_older_d = 1'b1;
        end
    end

    // Write port register: address/data hold when idle, only WE drops.
    always_comb begin
        reg_write_d = any_grant;
        wr_rd_d     = wr_rd_q;
        wr_data_d   = wr_data_q;
        if (any_grant) begin
            wr_rd_d   = (grant_src == SRC_ALU) ? alu_slot_rd   : ld_slot_rd;
            wr_data_d = (grant_src == SRC_ALU) ? alu_slot_data : ld_slot_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_alu_q    <= 1'b1;
            ld_older_q  <= 1'b1;
            reg_write_q <= 1'b0;
            wr_rd_q     <= '0;
            wr_data_q   <= '0;
        end else begin
            rr_alu_q    <= rr_alu_d;
            ld_older_q  <= ld_older_d;
            reg_write_q <= reg_write_d;
            wr_rd_q     <= wr_rd_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // A write stays pending until it has been presented on the write port.
    always_comb begin
        pending_c = '0;
        if (alu_full) begin
            pending_c[alu_slot_rd] = 1'b1;
        end
        if (ld_full) begin
            pending_c[ld_slot_rd] = 1'b1;
        end
        if (reg_write_q) begin
            pending_c[wr_rd_q] = 1'b1;
        end
        pending_c[REG_ZERO] = 1'b0;
    end

    assign RegWrite = reg_write_q;
    assign rd       = wr_rd_q;
    assign ALUout   = wr_data_q;
    assign pending  = pending_c;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
    import regfile_wb_pkg::*;

    localparam int DW   = 32;
    localparam int RW   = 5;
    localparam int NREG = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alu_valid, alu_ready;
    logic [RW-1:0]   alu_rd;
    logic [DW-1:0]   alu_data;
    logic            ld_valid, ld_ready;
    logic [RW-1:0]   ld_rd;
    logic [DW-1:0]   ld_data;
    logic            RegWrite;
    logic [RW-1:0]   rd;
    logic [DW-1:0]   ALUout;
    logic [NREG-1:0] pending;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .DATA_WIDTH     (DW),
        .REG_DATA_WIDTH (RW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .RegWrite  (RegWrite),
        .rd        (rd),
        .ALUout    (ALUout),
        .pending   (pending)
    );

    typedef struct {
        logic          rst_n;
        logic          alu_valid;
        logic [RW-1:0] alu_rd;
        logic [DW-1:0] alu_data;
        logic          ld_valid;
        logic [RW-1:0] ld_rd;
        logic [DW-1:0] ld_data;
    } stim_t;

    typedef struct {
        stim_t           stim;
        logic            e_ardy;
        logic            e_lrdy;
        logic            e_we;
        logic [RW-1:0]   e_rd;
        logic [DW-1:0]   e_data;
        logic [NREG-1:0] e_pend;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: index 0 = ALU, 1 = load. Age is an acceptance
    // timestamp; simultaneous acceptance ranks the load entry first.
    bit      m_full[2];
    wb_req_t m_req[2];
    int      m_stamp[2];
    bit      m_rr_alu = 1'b1;
    bit      m_we = 1'b0;
    wb_req_t m_out = '0;
    int      m_cycle = 0;
    int      m_acc_cnt[NREG];
    int      dut_wr_cnt[NREG];

    function automatic stim_t mkStim(input logic r, input logic av, input logic [RW-1:0] ar,
                                     input logic [DW-1:0] ad, input logic lv,
                                     input logic [RW-1:0] lr, input logic [DW-1:0] ldd);
        stim_t s;
        s.rst_n = r; s.alu_valid = av; s.alu_rd = ar; s.alu_data = ad;
        s.ld_valid = lv; s.ld_rd = lr; s.ld_data = ldd;
        return s;
    endfunction

    function automatic vec_t mkVec(input stim_t s, input logic ear, input logic elr, input logic ewe,
                                   input logic [RW-1:0] erd, input logic [DW-1:0] edat,
                                   input logic [NREG-1:0] epend);
        vec_t v;
        v.stim = s; v.e_ardy = ear; v.e_lrdy = elr; v.e_we = ewe;
        v.e_rd = erd; v.e_data = edat; v.e_pend = epend;
        return v;
    endfunction

    function automatic int modelGrant();
        if (m_full[0] && m_full[1]) begin
            if (m_req[0].rd == m_req[1].rd) return (m_stamp[0] < m_stamp[1]) ? 0 : 1;
            return m_rr_alu ? 0 : 1;
        end
        if (m_full[0]) return 0;
        if (m_full[1]) return 1;
        return -1;
    endfunction

    function automatic logic [NREG-1:0] modelPending();
        logic [NREG-1:0] p = '0;
        for (int s = 0; s < 2; s++) if (m_full[s]) p[m_req[s].rd] = 1'b1;
        if (m_we) p[m_out.rd] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic modelEdge(input stim_t st);
        int      g;
        bit      vld[2];
        wb_req_t inq[2];
        bit      rdy;
        if (!st.rst_n) begin
            m_full[0] = 1'b0; m_full[1] = 1'b0;
            m_rr_alu = 1'b1; m_we = 1'b0; m_out = '0;
            m_cycle++;
            return;
        end
        vld[0] = st.alu_valid; inq[0].rd = st.alu_rd; inq[0].data = st.alu_data;
        vld[1] = st.ld_valid;  inq[1].rd = st.ld_rd;  inq[1].data = st.ld_data;
        g = modelGrant();
        if (m_full[0] && m_full[1] && (m_req[0].rd != m_req[1].rd)) m_rr_alu = !m_rr_alu;
        if (g >= 0) begin
            m_we = 1'b1;
            m_out = m_req[g];
        end else begin
            m_we = 1'b0;
        end
        for (int s = 0; s < 2; s++) begin
            rdy = !m_full[s] || (g == s);
            if (g == s) m_full[s] = 1'b0;
            if (vld[s] && rdy && inq[s].rd != 0) begin
                m_full[s] = 1'b1;
                m_req[s] = inq[s];
                m_stamp[s] = m_cycle * 2 + ((s == 0) ? 1 : 0);
                m_acc_cnt[inq[s].rd]++;
            end
        end
        m_cycle++;
    endtask

    task automatic applyStimulus(input stim_t st);
        rst_n = st.rst_n;
        alu_valid = st.alu_valid; alu_rd = st.alu_rd; alu_data = st.alu_data;
        ld_valid = st.ld_valid;   ld_rd = st.ld_rd;   ld_data = st.ld_data;
        @(posedge clk);
        modelEdge(st);
        #1;
        if (RegWrite === 1'b1) dut_wr_cnt[rd]++;
    endtask

    task automatic checkOutput(input string name);
        logic ear, elr;
        logic [NREG-1:0] ep;
        int g;
        g = modelGrant();
        ear = !m_full[0] || (g == 0);
        elr = !m_full[1] || (g == 1);
        ep = modelPending();
        vectors++;
        if ({alu_ready, ld_ready, RegWrite, rd, ALUout, pending} !==
            {ear, elr, m_we, m_out.rd, m_out.data, ep}) begin
            miscompares++;
            $display("[TB] FAIL %s: got ardy=%b lrdy=%b we=%b rd=%0d data=%h pend=%h, want ardy=%b lrdy=%b we=%b rd=%0d data=%h pend=%h",
                     name, alu_ready, ld_ready, RegWrite, rd, ALUout, pending,
                     ear, elr, m_we, m_out.rd, m_out.data, ep);
        end
    endtask

    task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        vectors++;
        if ({alu_ready, ld_ready, RegWrite, rd, ALUout, pending} !==
            {v.e_ardy, v.e_lrdy, v.e_we, v.e_rd, v.e_data, v.e_pend}) begin
            miscompares++;
            $display("[TB] FAIL table[%0d]: got ardy=%b lrdy=%b we=%b rd=%0d data=%h pend=%h, want ardy=%b lrdy=%b we=%b rd=%0d data=%h pend=%h",
                     idx, alu_ready, ld_ready, RegWrite, rd, ALUout, pending,
                     v.e_ardy, v.e_lrdy, v.e_we, v.e_rd, v.e_data, v.e_pend);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t  tbl[11];
        stim_t idle;
        stim_t rst;
        stim_t s;

        idle = mkStim(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        rst  = mkStim(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < NREG; i++) begin
            m_acc_cnt[i] = 0;
            dut_wr_cnt[i] = 0;
        end
        m_full[0] = 1'b0; m_full[1] = 1'b0;
        m_req[0] = '0; m_req[1] = '0;
        m_stamp[0] = 0; m_stamp[1] = 0;

        // Reset/idle, single ALU write to r5, x0 write, same-rd pair on r9.
        tbl[0]  = mkVec(rst,  1, 1, 0, 5'd0, 32'h0, 32'h0);
        tbl[1]  = mkVec(idle, 1, 1, 0, 5'd0, 32'h0, 32'h0);
        tbl[2]  = mkVec(mkStim(1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0),
                        1, 1, 0, 5'd0, 32'h0, 32'h0000_0020);
        tbl[3]  = mkVec(idle, 1, 1, 1, 5'd5, 32'hDEADBEEF, 32'h0000_0020);
        tbl[4]  = mkVec(idle, 1, 1, 0, 5'd5, 32'hDEADBEEF, 32'h0);
        tbl[5]  = mkVec(mkStim(1, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'h0),
                        1, 1, 0, 5'd5, 32'hDEADBEEF, 32'h0);
        tbl[6]  = mkVec(idle, 1, 1, 0, 5'd5, 32'hDEADBEEF, 32'h0);
        tbl[7]  = mkVec(mkStim(1, 1, 5'd9, 32'h1, 1, 5'd9, 32'h2),
                        0, 1, 0, 5'd5, 32'hDEADBEEF, 32'h0000_0200);
        tbl[8]  = mkVec(idle, 1, 1, 1, 5'd9, 32'h2, 32'h0000_0200);
        tbl[9]  = mkVec(idle, 1, 1, 1, 5'd9, 32'h1, 32'h0000_0200);
        tbl[10] = mkVec(idle, 1, 1, 0, 5'd9, 32'h1, 32'h0);

        rst_n = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0;
        alu_rd = '0; ld_rd = '0; alu_data = '0; ld_data = '0;
        applyStimulus(rst);
        for (int i = 0; i < 11; i++) begin
            applyStimulus(tbl[i].stim);
            checkVector(i, tbl[i]);
        end

        // Continuous contention, different destinations: strict alternation.
        applyStimulus(rst);
        checkOutput("contend_reset");
        for (int i = 0; i < NREG; i++) begin
            m_acc_cnt[i] = 0;
            dut_wr_cnt[i] = 0;
        end
        for (int k = 0; k < 20; k++) begin
            applyStimulus(mkStim(1, 1, 5'd3, 32'h100 + k, 1, 5'd7, 32'h200 + k));
            checkOutput("contend");
            checkValue("contend_ready", {62'd0, alu_ready, ld_ready}, (k % 2 == 0) ? 64'h2 : 64'h1);
            if (k >= 1)
                checkValue("contend_alternate", {58'd0, RegWrite, rd},
                           {58'd0, 1'b1, (k % 2 == 1) ? 5'd3 : 5'd7});
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(idle);
            checkOutput("contend_drain");
        end
        checkValue("no_loss_alu_r3", 64'(dut_wr_cnt[3]), 64'(m_acc_cnt[3]));
        checkValue("no_loss_ld_r7",  64'(dut_wr_cnt[7]), 64'(m_acc_cnt[7]));
        checkValue("no_loss_alu_r3_total", 64'(dut_wr_cnt[3]), 64'd11);

        // Age beats rr: load entry older with rr pointing at ALU, both on r12.
        applyStimulus(rst);
        checkOutput("age_reset");
        for (int j = 0; j < 7; j++) begin
            case (j)
                0: s = mkStim(1, 1, 5'd3,  32'hA0, 1, 5'd7,  32'hB0);
                1: s = mkStim(1, 1, 5'd12, 32'hC0, 0, 5'd0,  32'h0);
                2: s = mkStim(1, 0, 5'd0,  32'h0,  1, 5'd12, 32'hD0);
                3: s = mkStim(1, 1, 5'd12, 32'hE0, 0, 5'd0,  32'h0);
                default: s = idle;
            endcase
            applyStimulus(s);
            checkOutput("age");
            if (j == 4) checkValue("age_load_first", {26'd0, RegWrite, rd, ALUout}, {26'd0, 1'b1, 5'd12, 32'hD0});
            if (j == 5) checkValue("age_alu_second", {26'd0, RegWrite, rd, ALUout}, {26'd0, 1'b1, 5'd12, 32'hE0});
        end

        // Reset with both buffers full discards everything.
        applyStimulus(mkStim(1, 1, 5'd4, 32'h44, 1, 5'd6, 32'h66));
        checkOutput("midreset_fill");
        applyStimulus(rst);
        checkValue("midreset_state", {29'd0, alu_ready, ld_ready, RegWrite, pending}, {29'd0, 3'b110, 32'h0});
        applyStimulus(idle);
        checkOutput("midreset_after");
        checkValue("midreset_pending", {32'd0, pending}, 64'd0);

        // Randomized traffic against the model, including occasional resets.
        for (int n = 0; n < 600; n++) begin
            s.rst_n     = ($urandom_range(0, 99) != 0);
            s.alu_valid = ($urandom_range(0, 9) < 7);
            s.ld_valid  = ($urandom_range(0, 9) < 7);
            s.alu_rd    = ($urandom_range(0, 3) == 0) ? RW'($urandom) : RW'($urandom_range(0, 3));
            s.ld_rd     = ($urandom_range(0, 3) == 0) ? RW'($urandom) : RW'($urandom_range(0, 3));
            s.alu_data  = $urandom;
            s.ld_data   = $urandom;
            applyStimulus(s);
            checkOutput("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port (RegWrite / rd / ALUout) between two writeback requesters: the ALU result path and the load-data path.
- Each source has a one-entry holding buffer with a valid/ready handshake.
- Arbitration is round-robin, with same-destination ordering preserved.
- The write port is driven from registers.
- A pending-write bitmask is exported so decode can stall reads of registers with uncommitted writes.
- The block sits between the execute/memory stages and the register file.

Parameters:
DATA_WIDTH, 32, width of write data
REG_DATA_WIDTH, 5, register address width; register count is 2**REG_DATA_WIDTH

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU buffer can accept
alu_rd  in  REG_DATA_WIDTH  ALU destination register
alu_data  in  DATA_WIDTH  ALU result
ld_valid  in  1  load writeback request
ld_ready  out  1  load buffer can accept
ld_rd  in  REG_DATA_WIDTH  load destination register
ld_data  in  DATA_WIDTH  load data
RegWrite  out  1  register file write enable (WE3)
rd  out  REG_DATA_WIDTH  register file write address (A3)
ALUout  out  DATA_WIDTH  register file write data (WD3)
pending  out  2**REG_DATA_WIDTH  bit i set = write to register i accepted but not yet presented to the register file

Behaviour:
- Reset (rst_n low at a rising edge):
  - Both buffers empty; age flag = load-older; rr pointer = ALU-first.
  - Outputs: RegWrite=0, rd=0, ALUout=0, pending=0.
  - Reset mid-operation discards all buffered writes.
  - alu_ready and ld_ready are 1 from the first cycle after reset.
- Per-source buffer: full flag, rd, data.
  - x_ready = !full || granted_x (combinational; a full buffer can refill in the same cycle it drains).
  - Accept on x_valid && x_ready at the rising edge.
- x0 filter: an accepted request with rd==0 completes the handshake but is not buffered. It is never written and never sets pending.
- Arbitration (combinational over current buffer state):
  - Neither buffer full: no grant.
  - One buffer full: grant it.
  - Both full with equal rd: grant the older entry.
  - Both full with different rd: grant the source indicated by rr, then toggle rr. rr changes only on contended grants.
- Age flag:
  - A buffer filling while the other is full and not being granted makes the other the older entry.
  - Both filling in the same cycle: load is older.
  - A sole remaining entry is older by definition.
- Output register: each edge loads RegWrite <= any_grant, rd <= granted rd, ALUout <= granted data. With no grant, RegWrite <= 0 and rd/ALUout hold their previous values.
- Latency:
  - Request accepted at edge E0 into an empty, uncontested buffer.
  - RegWrite is high during the cycle after E1.
  - The register file commits at E2.
- Throughput: one write per cycle total. Under continuous contention each source gets alternate cycles.
- pending = OR of one-hot(rd) over full buffers and the output register while RegWrite=1. Bit 0 is forced to 0.
- Back-to-back writes to the same rd from the same source are committed in acceptance order. This is inherent to the one-entry buffer.

Decomposition:
- Package regfile_wb_pkg:
  - typedef wb_req_t {rd, data}.
  - Source enum {SRC_ALU, SRC_LD}.
  - Constant REG_ZERO = 0.
- One sub-module, wb_slot: the one-entry buffer with ready/valid, x0 filter and fill/drain strobes. Instantiated twice.
- Arbitration, age, rr and output register live in the top module.

Test Plan:
- Reset then idle: alu_ready=ld_ready=1, RegWrite=0, pending=0 every cycle. Assert rst_n=0 with both buffers full: next cycle buffers are empty and pending=0.
- Single ALU write rd=5, data=0xDEADBEEF accepted at E0: pending[5]=1 after E0. After E1: RegWrite=1, rd=5, ALUout=0xDEADBEEF. After E2: RegWrite=0, pending[5]=0.
- Both sources valid every cycle with different rd (ALU rd=3, load rd=7, data incrementing): writes alternate ALU, load, ALU… starting with ALU. Each source's ready toggles; one write per cycle; no request lost.
- Both accepted in the same cycle with rd=9, ALU 0x1, load 0x2: load is written first, then ALU. The final value in r9 is 0x1.
- ALU write to rd=0 with data=0xFFFFFFFF: handshake completes in one cycle, RegWrite never asserts, pending stays 0.
- Load buffer full, ALU fills at the next edge with the same rd=12: the load entry is granted first even though rr points to ALU.
